// File: rtl/tlb_op_sequencer.sv
// Sequences tlbp/tlbr/tlbwi/tlbwr against a single-port, synchronous-read
// TLB array, stalling MEM and handing one-cycle results to CP0.
module tlb_op_sequencer #(
    parameter int TLB_LINE_NUM = 16,
    parameter int IDX_W        = $clog2(TLB_LINE_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [3:0]       op_type,
    input  logic             flush,
    input  logic             stage_advance,
    input  logic [31:0]      index_i,
    input  logic [31:0]      random_i,
    input  logic [31:0]      entry_hi_i,
    input  logic [31:0]      page_mask_i,
    input  logic [31:0]      entry_lo0_i,
    input  logic [31:0]      entry_lo1_i,
    output logic [IDX_W-1:0] tlb_rd_idx,
    input  logic [31:0]      tlb_rd_hi,
    input  logic [31:0]      tlb_rd_mask,
    input  logic [31:0]      tlb_rd_lo0,
    input  logic [31:0]      tlb_rd_lo1,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_wr_idx,
    output logic [31:0]      tlb_wr_hi,
    output logic [31:0]      tlb_wr_mask,
    output logic [31:0]      tlb_wr_lo0,
    output logic [31:0]      tlb_wr_lo1,
    output logic             stall_o,
    output logic [3:0]       tlb_type_o,
    output logic [31:0]      index_o,
    output logic [31:0]      entry_hi_o,
    output logic [31:0]      page_mask_o,
    output logic [31:0]      entry_lo0_o,
    output logic [31:0]      entry_lo1_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WRITE    = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_CAP   = 3'd3;
    localparam logic [2:0] S_PROBE    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_LINE_NUM - 1);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [3:0]       type_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      hi_q;
    logic [31:0]      mask_q;
    logic [31:0]      lo0_q;
    logic [31:0]      lo1_q;
    logic [IDX_W-1:0] probe_idx_q;
    logic [IDX_W-1:0] cmp_idx_q;
    logic             miss_q;
    logic             first_q;
    logic [31:0]      index_q;
    logic [31:0]      ehi_q;
    logic [31:0]      pmask_q;
    logic [31:0]      elo0_q;
    logic [31:0]      elo1_q;

    logic [3:0]  sel_type;
    logic        accept;
    logic [11:0] rd_mask;
    logic        rd_g;
    logic        vpn_hit;
    logic        asid_hit;
    logic        hit;
    logic [31:0] cap_hi;
    logic [31:0] cap_lo0;
    logic [31:0] cap_lo1;
    logic        unused_bits;

    assign unused_bits = ^{index_i[31:IDX_W], random_i[31:IDX_W]};

    // Several bits set: tlbp wins, then tlbr, tlbwi, tlbwr.
    always_comb begin
        sel_type = 4'b0000;
        priority case (1'b1)
            op_type[0]: sel_type = 4'b0001;
            op_type[1]: sel_type = 4'b0010;
            op_type[2]: sel_type = 4'b0100;
            op_type[3]: sel_type = 4'b1000;
            default:    sel_type = 4'b0000;
        endcase
    end

    assign accept = (state_q == S_IDLE) & op_valid
                  & (|op_type) & ~flush;

    assign rd_mask  = tlb_rd_mask[24:13];
    assign rd_g     = tlb_rd_lo0[0] & tlb_rd_lo1[0];
    assign vpn_hit  = ((tlb_rd_hi[31:13] ^ hi_q[31:13])
                    & ~{7'b0, rd_mask}) == 19'b0;
    assign asid_hit = tlb_rd_hi[7:0] == hi_q[7:0];
    assign hit      = vpn_hit & (rd_g | asid_hit);

    assign cap_hi  = {tlb_rd_hi[31:13] & ~{7'b0, rd_mask},
                      tlb_rd_hi[12:0]};
    assign cap_lo0 = {tlb_rd_lo0[31:30],
                      tlb_rd_lo0[29:6] & ~{12'b0, rd_mask},
                      tlb_rd_lo0[5:1], rd_g};
    assign cap_lo1 = {tlb_rd_lo1[31:30],
                      tlb_rd_lo1[29:6] & ~{12'b0, rd_mask},
                      tlb_rd_lo1[5:1], rd_g};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (sel_type[0])      state_d = S_PROBE;
                    else if (sel_type[1]) state_d = S_RD_ISSUE;
                    else                  state_d = S_WRITE;
                end
            end
            S_WRITE:    state_d = S_DONE;
            S_RD_ISSUE: state_d = S_RD_CAP;
            S_RD_CAP:   state_d = S_DONE;
            S_PROBE: begin
                if (miss_q | hit) state_d = S_DONE;
            end
            S_DONE: begin
                if (!(op_valid & ~stage_advance)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            type_q      <= 4'b0;
            idx_q       <= '0;
            hi_q        <= 32'b0;
            mask_q      <= 32'b0;
            lo0_q       <= 32'b0;
            lo1_q       <= 32'b0;
            probe_idx_q <= '0;
            cmp_idx_q   <= '0;
            miss_q      <= 1'b0;
            first_q     <= 1'b0;
            index_q     <= 32'b0;
            ehi_q       <= 32'b0;
            pmask_q     <= 32'b0;
            elo0_q      <= 32'b0;
            elo1_q      <= 32'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d == S_DONE) && (state_q != S_DONE);
            if (accept) begin
                type_q      <= sel_type;
                idx_q       <= sel_type[3] ? random_i[IDX_W-1:0]
                                           : index_i[IDX_W-1:0];
                hi_q        <= entry_hi_i;
                mask_q      <= page_mask_i;
                lo0_q       <= entry_lo0_i;
                lo1_q       <= entry_lo1_i;
                // entry 0 is read during the accept cycle itself
                probe_idx_q <= IDX_W'(1);
                cmp_idx_q   <= '0;
                miss_q      <= 1'b0;
            end
            if (state_q == S_PROBE && !flush) begin
                if (miss_q) begin
                    index_q <= 32'h8000_0000;
                end else if (hit) begin
                    index_q <= {{(32-IDX_W){1'b0}}, cmp_idx_q};
                end else begin
                    if (cmp_idx_q == LAST_IDX) miss_q <= 1'b1;
                    else cmp_idx_q <= cmp_idx_q + IDX_W'(1);
                    if (probe_idx_q != LAST_IDX)
                        probe_idx_q <= probe_idx_q + IDX_W'(1);
                end
            end
            if (state_q == S_RD_CAP && !flush) begin
                ehi_q   <= cap_hi;
                pmask_q <= tlb_rd_mask;
                elo0_q  <= cap_lo0;
                elo1_q  <= cap_lo1;
            end
            if (state_d == S_IDLE) begin
                probe_idx_q <= '0;
                cmp_idx_q   <= '0;
                miss_q      <= 1'b0;
            end
        end
    end

    assign stall_o    = accept
                      | ((state_q != S_IDLE) && (state_q != S_DONE));
    assign tlb_we     = (state_q == S_WRITE) & ~flush;
    assign tlb_type_o = ((state_q == S_DONE) && first_q && !flush)
                      ? type_q : 4'b0;
    assign tlb_rd_idx = (state_q == S_RD_ISSUE) ? idx_q : probe_idx_q;

    assign tlb_wr_idx  = idx_q;
    assign tlb_wr_hi   = hi_q;
    assign tlb_wr_mask = mask_q;
    assign tlb_wr_lo0  = lo0_q;
    assign tlb_wr_lo1  = lo1_q;

    assign index_o     = index_q;
    assign entry_hi_o  = ehi_q;
    assign page_mask_o = pmask_q;
    assign entry_lo0_o = elo0_q;
    assign entry_lo1_o = elo1_q;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed bench for tlb_op_sequencer with a behavioural
// synchronous-read TLB array model.
module tb_tlb_op_sequencer;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op_type;
    logic        flush;
    logic        stage_advance;
    logic [31:0] index_i;
    logic [31:0] random_i;
    logic [31:0] entry_hi_i;
    logic [31:0] page_mask_i;
    logic [31:0] entry_lo0_i;
    logic [31:0] entry_lo1_i;
    logic [3:0]  tlb_rd_idx;
    logic [31:0] tlb_rd_hi;
    logic [31:0] tlb_rd_mask;
    logic [31:0] tlb_rd_lo0;
    logic [31:0] tlb_rd_lo1;
    logic        tlb_we;
    logic [3:0]  tlb_wr_idx;
    logic [31:0] tlb_wr_hi;
    logic [31:0] tlb_wr_mask;
    logic [31:0] tlb_wr_lo0;
    logic [31:0] tlb_wr_lo1;
    logic        stall_o;
    logic [3:0]  tlb_type_o;
    logic [31:0] index_o;
    logic [31:0] entry_hi_o;
    logic [31:0] page_mask_o;
    logic [31:0] entry_lo0_o;
    logic [31:0] entry_lo1_o;

    int checks;
    int failures;

    logic [31:0] m_hi   [16];
    logic [31:0] m_mask [16];
    logic [31:0] m_lo0  [16];
    logic [31:0] m_lo1  [16];

    tlb_op_sequencer #(.TLB_LINE_NUM(16)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_type(op_type),
        .flush(flush), .stage_advance(stage_advance),
        .index_i(index_i), .random_i(random_i),
        .entry_hi_i(entry_hi_i), .page_mask_i(page_mask_i),
        .entry_lo0_i(entry_lo0_i), .entry_lo1_i(entry_lo1_i),
        .tlb_rd_idx(tlb_rd_idx), .tlb_rd_hi(tlb_rd_hi),
        .tlb_rd_mask(tlb_rd_mask), .tlb_rd_lo0(tlb_rd_lo0),
        .tlb_rd_lo1(tlb_rd_lo1), .tlb_we(tlb_we),
        .tlb_wr_idx(tlb_wr_idx), .tlb_wr_hi(tlb_wr_hi),
        .tlb_wr_mask(tlb_wr_mask), .tlb_wr_lo0(tlb_wr_lo0),
        .tlb_wr_lo1(tlb_wr_lo1), .stall_o(stall_o),
        .tlb_type_o(tlb_type_o), .index_o(index_o),
        .entry_hi_o(entry_hi_o), .page_mask_o(page_mask_o),
        .entry_lo0_o(entry_lo0_o), .entry_lo1_o(entry_lo1_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Entry i starts as VPN2 0x100+i, ASID 0x11, G=0, mask 0.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_hi[i]   <= ((32'd256 + 32'(i)) << 13) | 32'h11;
                m_mask[i] <= 32'h0;
                m_lo0[i]  <= 32'h0;
                m_lo1[i]  <= 32'h0;
            end
        end else if (tlb_we) begin
            m_hi[tlb_wr_idx]   <= tlb_wr_hi;
            m_mask[tlb_wr_idx] <= tlb_wr_mask;
            m_lo0[tlb_wr_idx]  <= tlb_wr_lo0;
            m_lo1[tlb_wr_idx]  <= tlb_wr_lo1;
        end
        tlb_rd_hi   <= m_hi[tlb_rd_idx];
        tlb_rd_mask <= m_mask[tlb_rd_idx];
        tlb_rd_lo0  <= m_lo0[tlb_rd_idx];
        tlb_rd_lo1  <= m_lo1[tlb_rd_idx];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] t, input logic [31:0] idx,
                            input logic [31:0] rnd, input logic [31:0] hi,
                            input logic [31:0] pm, input logic [31:0] l0,
                            input logic [31:0] l1);
        op_type       = t;
        index_i       = idx;
        random_i      = rnd;
        entry_hi_i    = hi;
        page_mask_i   = pm;
        entry_lo0_i   = l0;
        entry_lo1_i   = l1;
        op_valid      = 1'b1;
        stage_advance = 1'b0;
        #1;
    endtask

    task automatic release_op();
        op_valid      = 1'b0;
        op_type       = 4'b0;
        stage_advance = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        op_valid = 1'b0;
        op_type = 4'b0;
        flush = 1'b0;
        stage_advance = 1'b1;
        index_i = 32'h0;
        random_i = 32'h0;
        entry_hi_i = 32'h0;
        page_mask_i = 32'h0;
        entry_lo0_i = 32'h0;
        entry_lo1_i = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_type", 32'(tlb_type_o), 32'h0);
        chk("rst_we", 32'(tlb_we), 32'h0);
        chk("rst_index", index_o, 32'h0);
        chk("rst_rdidx", 32'(tlb_rd_idx), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // T1 tlbwi index 5
        start_op(4'b0100, 32'd5, 32'd3, 32'h0040_2001, 32'h0,
                 32'h0000_0141, 32'h0000_0181);
        chk("t1_stall_c0", 32'(stall_o), 32'h1);
        @(negedge clk);
        chk("t1_we_c1", 32'(tlb_we), 32'h1);
        chk("t1_wridx", 32'(tlb_wr_idx), 32'd5);
        chk("t1_wrhi", tlb_wr_hi, 32'h0040_2001);
        chk("t1_stall_c1", 32'(stall_o), 32'h1);
        @(negedge clk);
        chk("t1_type_c2", 32'(tlb_type_o), 32'h4);
        chk("t1_stall_c2", 32'(stall_o), 32'h0);
        chk("t1_we_c2", 32'(tlb_we), 32'h0);
        release_op();
        chk("t1_type_c3", 32'(tlb_type_o), 32'h0);
        chk("t1_mem5", m_hi[5], 32'h0040_2001);

        // T2 tlbwr random 9, then tlbr 9
        start_op(4'b1000, 32'd5, 32'd9, 32'h1234_6055, 32'h0,
                 32'h0012_3457, 32'h0045_6783);
        @(negedge clk);
        chk("t2_we", 32'(tlb_we), 32'h1);
        chk("t2_wridx", 32'(tlb_wr_idx), 32'd9);
        @(negedge clk);
        chk("t2_type_wr", 32'(tlb_type_o), 32'h8);
        release_op();
        start_op(4'b0010, 32'd9, 32'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("t2_stall_c0", 32'(stall_o), 32'h1);
        @(negedge clk);
        chk("t2_rdidx", 32'(tlb_rd_idx), 32'd9);
        @(negedge clk);
        chk("t2_stall_c2", 32'(stall_o), 32'h1);
        chk("t2_type_c2", 32'(tlb_type_o), 32'h0);
        @(negedge clk);
        chk("t2_type_c3", 32'(tlb_type_o), 32'h2);
        chk("t2_stall_c3", 32'(stall_o), 32'h0);
        chk("t2_ehi", entry_hi_o, 32'h1234_6055);
        chk("t2_lo0", entry_lo0_o, 32'h0012_3457);
        chk("t2_lo1", entry_lo1_o, 32'h0045_6783);
        chk("t2_pmask", page_mask_o, 32'h0);
        release_op();

        // multi-bit op_type: tlbr beats tlbwi
        start_op(4'b0110, 32'd9, 32'd2, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("pri_we", 32'(tlb_we), 32'h0);
        chk("pri_rdidx", 32'(tlb_rd_idx), 32'd9);
        repeat (2) @(negedge clk);
        chk("pri_type", 32'(tlb_type_o), 32'h2);
        release_op();

        // T3 tlbp hit at 7, then full miss
        start_op(4'b0001, 32'd0, 32'd0, 32'h0020_E011, 32'h0,
                 32'h0, 32'h0);
        repeat (8) @(negedge clk);
        chk("t3_stall_c8", 32'(stall_o), 32'h1);
        chk("t3_type_c8", 32'(tlb_type_o), 32'h0);
        @(negedge clk);
        chk("t3_index", index_o, 32'd7);
        chk("t3_type_c9", 32'(tlb_type_o), 32'h1);
        chk("t3_stall_c9", 32'(stall_o), 32'h0);
        release_op();
        start_op(4'b0001, 32'd0, 32'd0, 32'h7FFF_E011, 32'h0,
                 32'h0, 32'h0);
        repeat (17) @(negedge clk);
        chk("t3m_stall_c17", 32'(stall_o), 32'h1);
        @(negedge clk);
        chk("t3m_index", index_o, 32'h8000_0000);
        chk("t3m_type_c18", 32'(tlb_type_o), 32'h1);
        release_op();

        // T4 global bit, ASID mismatch, page mask
        start_op(4'b0001, 32'd0, 32'd0, 32'h1234_6022, 32'h0,
                 32'h0, 32'h0);
        repeat (10) @(negedge clk);
        chk("t4g_stall_c10", 32'(stall_o), 32'h1);
        @(negedge clk);
        chk("t4g_index", index_o, 32'd9);
        chk("t4g_type", 32'(tlb_type_o), 32'h1);
        release_op();
        start_op(4'b0001, 32'd0, 32'd0, 32'h0020_E022, 32'h0,
                 32'h0, 32'h0);
        repeat (18) @(negedge clk);
        chk("t4a_index", index_o, 32'h8000_0000);
        chk("t4a_type", 32'(tlb_type_o), 32'h1);
        release_op();
        start_op(4'b0100, 32'd12, 32'd0, 32'hABC2_4033, 32'h01FF_E000,
                 32'h0000_3FC5, 32'h0000_0002);
        repeat (2) @(negedge clk);
        chk("t4w_type", 32'(tlb_type_o), 32'h4);
        release_op();
        start_op(4'b0010, 32'd12, 32'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("t4r_ehi", entry_hi_o, 32'hAA00_0033);
        chk("t4r_pmask", page_mask_o, 32'h01FF_E000);
        chk("t4r_lo0", entry_lo0_o, 32'h0000_0004);
        chk("t4r_lo1", entry_lo1_o, 32'h0000_0002);
        release_op();
        start_op(4'b0001, 32'd0, 32'd0, 32'hAB3F_E033, 32'h0,
                 32'h0, 32'h0);
        repeat (14) @(negedge clk);
        chk("t4m_index", index_o, 32'd12);
        chk("t4m_type", 32'(tlb_type_o), 32'h1);
        release_op();

        // T5 flush with accept, then flush during WRITE
        op_type = 4'b0100;
        index_i = 32'd3;
        entry_hi_i = 32'hDEAD_0000;
        op_valid = 1'b1;
        stage_advance = 1'b0;
        flush = 1'b1;
        #1;
        chk("t5_nacc_stall", 32'(stall_o), 32'h0);
        @(negedge clk);
        chk("t5_nacc_we", 32'(tlb_we), 32'h0);
        chk("t5_nacc_stall2", 32'(stall_o), 32'h0);
        flush = 1'b0;
        #1;
        chk("t5_stall_c0", 32'(stall_o), 32'h1);
        @(negedge clk);
        flush = 1'b1;
        op_valid = 1'b0;
        #1;
        chk("t5_we_gated", 32'(tlb_we), 32'h0);
        @(negedge clk);
        flush = 1'b0;
        chk("t5_stall_c2", 32'(stall_o), 32'h0);
        chk("t5_type_c2", 32'(tlb_type_o), 32'h0);
        chk("t5_we_c2", 32'(tlb_we), 32'h0);
        @(negedge clk);
        chk("t5_type_c3", 32'(tlb_type_o), 32'h0);
        chk("t5_mem3", m_hi[3], 32'h0020_6011);
        op_type = 4'b0;
        stage_advance = 1'b1;
        @(negedge clk);

        // T6 DONE held three cycles
        start_op(4'b0100, 32'd4, 32'd0, 32'h0BAD_0000, 32'h0,
                 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("t6_type_c2", 32'(tlb_type_o), 32'h4);
        chk("t6_stall_c2", 32'(stall_o), 32'h0);
        for (int c = 3; c < 5; c++) begin
            @(negedge clk);
            chk("t6_type_hold", 32'(tlb_type_o), 32'h0);
            chk("t6_stall_hold", 32'(stall_o), 32'h0);
            chk("t6_we_hold", 32'(tlb_we), 32'h0);
        end
        release_op();
        chk("t6_type_idle", 32'(tlb_type_o), 32'h0);
        chk("t6_stall_idle", 32'(stall_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
